// File: rtl/memory_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch port and the load/store port.
// Optional build macro ROUND_ROBIN_EN alternates the winner under contention; default is data-over-fetch.
module memory_port_arbiter #(
   parameter int READ_LATENCY  = 1,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_request,
   input  logic [ADDRESS_WIDTH-1:0] fetch_address,
   output logic                     fetch_grant,
   output logic                     fetch_done,
   output logic [31:0]              fetch_data,
   input  logic                     data_request,
   input  logic [ADDRESS_WIDTH-1:0] data_address,
   input  logic [2:0]               data_write_sections,
   input  logic [31:0]              data_write_value,
   output logic                     data_grant,
   output logic                     data_done,
   output logic [31:0]              data_read_value,
   output logic                     memory_enable,
   output logic [ADDRESS_WIDTH-1:0] memory_address,
   output logic [2:0]               memory_write_sections,
   output logic [31:0]              memory_write_value,
   input  logic [31:0]              memory_read_value
);

   localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t                   state, state_nxt;
   logic                     owner_data, owner_data_nxt;
   logic [CNT_W-1:0]         wait_cnt, wait_cnt_nxt;
   logic                     data_wins;

   logic                     fetch_grant_nxt, fetch_done_nxt;
   logic [31:0]              fetch_data_nxt;
   logic                     data_grant_nxt, data_done_nxt;
   logic [31:0]              data_read_value_nxt;
   logic                     memory_enable_nxt;
   logic [ADDRESS_WIDTH-1:0] memory_address_nxt;
   logic [2:0]               memory_write_sections_nxt;
   logic [31:0]              memory_write_value_nxt;

`ifdef ROUND_ROBIN_EN
   // Remembers who was served last; on contention the other port goes next.
   logic last_owner_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_owner_data <= 1'b0;
      else if (state == ACCESS)
         last_owner_data <= owner_data;
   end

   assign data_wins = data_request & (~fetch_request | ~last_owner_data);
`else
   assign data_wins = data_request;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                 <= IDLE;
         owner_data            <= 1'b0;
         wait_cnt              <= '0;
         fetch_grant           <= 1'b0;
         fetch_done            <= 1'b0;
         fetch_data            <= '0;
         data_grant            <= 1'b0;
         data_done             <= 1'b0;
         data_read_value       <= '0;
         memory_enable         <= 1'b0;
         memory_address        <= '0;
         memory_write_sections <= '0;
         memory_write_value    <= '0;
      end else begin
         state                 <= state_nxt;
         owner_data            <= owner_data_nxt;
         wait_cnt              <= wait_cnt_nxt;
         fetch_grant           <= fetch_grant_nxt;
         fetch_done            <= fetch_done_nxt;
         fetch_data            <= fetch_data_nxt;
         data_grant            <= data_grant_nxt;
         data_done             <= data_done_nxt;
         data_read_value       <= data_read_value_nxt;
         memory_enable         <= memory_enable_nxt;
         memory_address        <= memory_address_nxt;
         memory_write_sections <= memory_write_sections_nxt;
         memory_write_value    <= memory_write_value_nxt;
      end
   end

   // Every output is a register, so each transition computes next cycle's output values.
   always_comb begin
      state_nxt                 = state;
      owner_data_nxt            = owner_data;
      wait_cnt_nxt              = wait_cnt;
      fetch_grant_nxt           = 1'b0;
      fetch_done_nxt            = 1'b0;
      fetch_data_nxt            = fetch_data;
      data_grant_nxt            = 1'b0;
      data_done_nxt             = 1'b0;
      data_read_value_nxt       = data_read_value;
      memory_enable_nxt         = 1'b0;
      memory_address_nxt        = memory_address;
      memory_write_sections_nxt = 3'b000;
      memory_write_value_nxt    = memory_write_value;

      unique case (state)
         IDLE: begin
            if (fetch_request | data_request) begin
               state_nxt         = ACCESS;
               owner_data_nxt    = data_wins;
               memory_enable_nxt = 1'b1;
               if (data_wins) begin
                  data_grant_nxt            = 1'b1;
                  memory_address_nxt        = data_address;
                  memory_write_sections_nxt = data_write_sections;
                  memory_write_value_nxt    = data_write_value;
               end else begin
                  fetch_grant_nxt    = 1'b1;
                  memory_address_nxt = fetch_address;
               end
            end
         end
         ACCESS: begin
            if (memory_write_sections != 3'b000) begin
               state_nxt      = DONE;
               data_done_nxt  = owner_data;
               fetch_done_nxt = ~owner_data;
            end else begin
               state_nxt    = WAIT;
               wait_cnt_nxt = CNT_W'(READ_LATENCY);
            end
         end
         WAIT: begin
            if (wait_cnt == CNT_W'(1)) begin
               state_nxt = DONE;
               if (owner_data) begin
                  data_done_nxt       = 1'b1;
                  data_read_value_nxt = memory_read_value;
               end else begin
                  fetch_done_nxt = 1'b1;
                  fetch_data_nxt = memory_read_value;
               end
            end else begin
               wait_cnt_nxt = wait_cnt - CNT_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized scoreboard bench for memory_port_arbiter with a transaction-level reference model.
// Follows ROUND_ROBIN_EN when the macro is defined for the build.
module tb_memory_port_arbiter;

   localparam int RL = 3;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_request;
   logic [AW-1:0] fetch_address;
   logic          fetch_grant, fetch_done;
   logic [31:0]   fetch_data;
   logic          data_request;
   logic [AW-1:0] data_address;
   logic [2:0]    data_write_sections;
   logic [31:0]   data_write_value;
   logic          data_grant, data_done;
   logic [31:0]   data_read_value;
   logic          memory_enable;
   logic [AW-1:0] memory_address;
   logic [2:0]    memory_write_sections;
   logic [31:0]   memory_write_value;
   logic [31:0]   memory_read_value;

   memory_port_arbiter #(.READ_LATENCY(RL), .ADDRESS_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .fetch_request(fetch_request), .fetch_address(fetch_address),
      .fetch_grant(fetch_grant), .fetch_done(fetch_done), .fetch_data(fetch_data),
      .data_request(data_request), .data_address(data_address),
      .data_write_sections(data_write_sections), .data_write_value(data_write_value),
      .data_grant(data_grant), .data_done(data_done), .data_read_value(data_read_value),
      .memory_enable(memory_enable), .memory_address(memory_address),
      .memory_write_sections(memory_write_sections), .memory_write_value(memory_write_value),
      .memory_read_value(memory_read_value)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors  = 0;

   function automatic logic [31:0] init_word(int i);
      return (32'(i) * 32'h0001_0203) ^ 32'hA500_0000;
   endfunction

   function automatic logic [31:0] apply_mask(logic [31:0] old, logic [2:0] s, logic [31:0] v);
      logic [31:0] r;
      r = old;
      if (s[2]) r[31:16] = v[31:16];
      if (s[1]) r[15:8]  = v[15:8];
      if (s[0]) r[7:0]   = v[7:0];
      return r;
   endfunction

   // Behavioural single-port RAM with RL-cycle read latency; off-cycles return noise.
   logic [31:0] ram [256];
   logic [31:0] rd_pipe [RL];
   assign memory_read_value = rd_pipe[RL-1];

   initial begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 8'h40) ? 32'hDEAD_BEEF : init_word(i);
      for (int i = 0; i < RL; i++) rd_pipe[i] <= 32'h0;
      forever begin
         @(posedge clk);
         for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
         if (memory_enable && memory_write_sections == 3'b000)
            rd_pipe[0] <= ram[memory_address[9:2]];
         else
            rd_pipe[0] <= $urandom;
         if (memory_enable && memory_write_sections != 3'b000)
            ram[memory_address[9:2]] <= apply_mask(ram[memory_address[9:2]],
                                                   memory_write_sections, memory_write_value);
      end
   end

   typedef struct { int cyc; logic is_data; } grant_t;
   typedef struct { int cyc; logic [31:0] addr; logic [2:0] sect; logic [31:0] val; logic is_data; } mem_t;
   typedef struct { int cyc; logic is_data; logic is_read; logic [31:0] val; } done_t;

   grant_t gq[$];
   mem_t   mq[$];
   done_t  dq[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [31:0] exp_fd, exp_dv, exp_maddr, exp_mval;
   logic        mval_known;

   task automatic check_all_zero(string tag);
      chk({tag, "_fetch_grant"}, 32'(fetch_grant), 0);
      chk({tag, "_fetch_done"}, 32'(fetch_done), 0);
      chk({tag, "_fetch_data"}, fetch_data, 0);
      chk({tag, "_data_grant"}, 32'(data_grant), 0);
      chk({tag, "_data_done"}, 32'(data_done), 0);
      chk({tag, "_data_read_value"}, data_read_value, 0);
      chk({tag, "_memory_enable"}, 32'(memory_enable), 0);
      chk({tag, "_memory_address"}, memory_address, 0);
      chk({tag, "_memory_write_sections"}, 32'(memory_write_sections), 0);
      chk({tag, "_memory_write_value"}, memory_write_value, 0);
   endtask

   task automatic monitor_cycle();
      grant_t g;
      mem_t   m;
      done_t  d;
      if (reset) begin
         check_all_zero("reset");
         exp_fd = 0; exp_dv = 0; exp_maddr = 0; exp_mval = 0; mval_known = 1'b1;
         return;
      end
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
         g = gq.pop_front();
         chk("fetch_grant", 32'(fetch_grant), 32'(!g.is_data));
         chk("data_grant", 32'(data_grant), 32'(g.is_data));
      end else begin
         chk("grant_quiet", 32'({fetch_grant, data_grant}), 0);
      end
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
         m = mq.pop_front();
         chk("memory_enable", 32'(memory_enable), 1);
         chk("memory_address", memory_address, m.addr);
         chk("memory_write_sections", 32'(memory_write_sections), 32'(m.sect));
         exp_maddr  = m.addr;
         mval_known = m.is_data;
         exp_mval   = m.val;
         if (m.is_data) chk("memory_write_value", memory_write_value, m.val);
      end else begin
         chk("memory_enable_idle", 32'(memory_enable), 0);
         chk("memory_write_sections_idle", 32'(memory_write_sections), 0);
         chk("memory_address_hold", memory_address, exp_maddr);
         if (mval_known) chk("memory_write_value_hold", memory_write_value, exp_mval);
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
         d = dq.pop_front();
         chk("fetch_done", 32'(fetch_done), 32'(!d.is_data));
         chk("data_done", 32'(data_done), 32'(d.is_data));
         if (d.is_read) begin
            if (d.is_data) exp_dv = d.val;
            else           exp_fd = d.val;
         end
      end else begin
         chk("done_quiet", 32'({fetch_done, data_done}), 0);
      end
      chk("fetch_data", fetch_data, exp_fd);
      chk("data_read_value", data_read_value, exp_dv);
   endtask

   initial begin
      exp_fd = 0; exp_dv = 0; exp_maddr = 0; exp_mval = 0; mval_known = 1'b1;
      forever begin
         @(negedge clk);
         monitor_cycle();
      end
   end

   // ---------------- reference model + stimulus ----------------
   logic [31:0] ref_mem [256];
   int   free_at      = 0;
   logic last_data    = 1'b0;
   int   fetch_gnt_at = -1;
   int   data_gnt_at  = -1;
   int   grants       = 0;

   function automatic logic data_preferred();
`ifdef ROUND_ROBIN_EN
      return !last_data;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h200 + (32'($urandom_range(0, 11)) << 2);
   endfunction

   task automatic model_eval();
      logic        pick;
      logic [31:0] a, v, rv;
      logic [2:0]  s;
      int          dc;
      if (reset || cyc < free_at || !(fetch_request || data_request)) return;
      pick = data_request && (!fetch_request || data_preferred());
      a  = pick ? data_address : fetch_address;
      s  = pick ? data_write_sections : 3'b000;
      v  = data_write_value;
      rv = 32'h0;
      gq.push_back('{cyc + 1, pick});
      mq.push_back('{cyc + 1, a, s, v, pick});
      if (s != 3'b000) begin
         ref_mem[a[9:2]] = apply_mask(ref_mem[a[9:2]], s, v);
         dc = cyc + 2;
      end else begin
         rv = ref_mem[a[9:2]];
         dc = cyc + 2 + RL;
      end
      dq.push_back('{dc, pick, (s == 3'b000), rv});
      free_at   = dc + 1;
      last_data = pick;
      grants++;
      if (pick) data_gnt_at = cyc + 1;
      else      fetch_gnt_at = cyc + 1;
   endtask

   // Requesters scramble their inputs in the grant cycle and drop the request the cycle after.
   task automatic step();
      @(posedge clk);
      #1;
      if (fetch_gnt_at >= 0) begin
         if (cyc == fetch_gnt_at) fetch_address = $urandom;
         else if (cyc > fetch_gnt_at) begin fetch_request = 1'b0; fetch_gnt_at = -1; end
      end
      if (data_gnt_at >= 0) begin
         if (cyc == data_gnt_at) begin
            data_address = $urandom; data_write_sections = 3'($urandom); data_write_value = $urandom;
         end else if (cyc > data_gnt_at) begin
            data_request = 1'b0; data_gnt_at = -1;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((fetch_request || data_request || cyc < free_at) && n < 400) begin
         step();
         model_eval();
         n++;
      end
      if (n >= 400) begin
         vectors++; errors++;
         $display("FAIL drain_timeout @cycle %0d: got %0d cycles want <400", cyc, n);
      end
   endtask

   task automatic raise_data(logic [31:0] a, logic [2:0] s, logic [31:0] v);
      data_request = 1'b1; data_address = a; data_write_sections = s; data_write_value = v;
   endtask

   initial begin
      int start_grants;
      reset = 1'b1;
      fetch_request = 1'b0; fetch_address = '0;
      data_request = 1'b0; data_address = '0; data_write_sections = '0; data_write_value = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = (i == 8'h40) ? 32'hDEAD_BEEF : init_word(i);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; free_at = cyc; last_data = 1'b0;

      // Fetch read of the preloaded word.
      fetch_request = 1'b1; fetch_address = 32'h100;
      model_eval();
      drain();

      // Byte store, then read it back.
      step();
      raise_data(32'h204, 3'b001, 32'h0000_00AB);
      model_eval();
      drain();
      step();
      raise_data(32'h204, 3'b000, 32'h1234_5678);
      model_eval();
      drain();

      // Simultaneous fetch and load.
      step();
      fetch_request = 1'b1; fetch_address = 32'h208;
      raise_data(32'h20C, 3'b000, 32'h0);
      model_eval();
      drain();

      // Continuous contention for four grants.
      start_grants = grants;
      for (int n = 0; n < 200 && grants - start_grants < 4; n++) begin
         step();
         if (!fetch_request) begin fetch_request = 1'b1; fetch_address = rand_addr(); end
         if (!data_request) raise_data(rand_addr(), 3'b000, $urandom);
         model_eval();
      end
      drain();

      // Randomized traffic with occasional withdrawals.
      for (int n = 0; n < 800; n++) begin
         step();
         if (!fetch_request && fetch_gnt_at < 0) begin
            if ($urandom_range(0, 99) < 30) begin fetch_request = 1'b1; fetch_address = rand_addr(); end
         end else if (fetch_request && fetch_gnt_at < 0 && $urandom_range(0, 99) < 3) begin
            fetch_request = 1'b0;
         end
         if (!data_request && data_gnt_at < 0) begin
            if ($urandom_range(0, 99) < 30)
               raise_data(rand_addr(), ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7)), $urandom);
         end else if (data_request && data_gnt_at < 0 && $urandom_range(0, 99) < 3) begin
            data_request = 1'b0;
         end
         model_eval();
      end
      drain();

      // Reset asserted while a fetch read is waiting on memory; the request stays held.
      step();
      fetch_request = 1'b1; fetch_address = 32'h104;
      model_eval();
      fetch_gnt_at = -1;
      step(); step(); step();
      reset = 1'b1;
      gq.delete(); mq.delete(); dq.delete();
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0; free_at = cyc; last_data = 1'b0;
      model_eval();
      drain();

      repeat (4) step();
      chk("leftover_expectations", 32'(gq.size() + mq.size() + dq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
